// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer and its synchroniser.
// Optional DEBOUNCE_GLITCH_CNT_EN adds an 8-bit aborted-change counter to the debouncer.
package debounce_pkg;

  typedef enum logic [0:0] {SETTLED, PENDING} db_state_t;

  localparam int DB_DEFAULT_STABLE_CYCLES = 4;
  localparam int DB_DEFAULT_SYNC_STAGES   = 2;

  // Counter must hold STABLE_CYCLES-1; keep at least one bit for tiny settings.
  function automatic int dbCounterWidth(input int stableCycles);
    return (stableCycles > 2) ? $clog2(stableCycles) : 1;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw level in, debounced level and status out.
// With DEBOUNCE_GLITCH_CNT_EN defined the bundle also carries glitchCount.
interface button_debouncer_if;
  import debounce_pkg::*;

  logic       btnIn;
  logic       btnOut;
  logic       stable;
  logic       btnChanged;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitchCount;
`endif

  modport master (
    output btnIn,
    input  btnOut,
    input  stable,
    input  btnChanged
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , input glitchCount
`endif
  );

  modport slave (
    input  btnIn,
    output btnOut,
    output stable,
    output btnChanged
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , output glitchCount
`endif
  );

endinterface

// File: rtl/button_debouncer_sync_chain.sv
// Generic N-flop synchroniser with a configurable asynchronous reset value;
// reusable for any asynchronous level input such as switches.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int   N         = DB_DEFAULT_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= {N{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[N-2:0], i_d};
    end
  end

  assign o_q = r_chain[N-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button: synchronise, then require STABLE_CYCLES agreeing cycles.
// Optional DEBOUNCE_GLITCH_CNT_EN adds a saturating count of aborted changes.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DB_DEFAULT_STABLE_CYCLES,
  parameter int   SYNC_STAGES   = DB_DEFAULT_SYNC_STAGES,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  button_debouncer_if.slave    bus
);

  localparam int             CNT_W    = dbCounterWidth(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_syncLvl;
  db_state_t        r_state;
  db_state_t        w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_nextCount;
  logic             r_btnOut;
  logic             w_nextBtnOut;
  logic             r_btnChanged;
  logic             w_changePulse;
  logic             r_stable;
  logic             w_abort;

  sync_chain #(
    .N         (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.btnIn),
    .o_q (w_syncLvl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= SETTLED;
      r_count      <= '0;
      r_btnOut     <= RESET_LEVEL;
      r_btnChanged <= 1'b0;
      r_stable     <= 1'b1;
    end else begin
      r_state      <= w_nextState;
      r_count      <= w_nextCount;
      r_btnOut     <= w_nextBtnOut;
      r_btnChanged <= w_changePulse;
      r_stable     <= (w_nextState == SETTLED);
    end
  end

  // A returning level or a terminal-count decision both use syncLvl at this edge only.
  always_comb begin
    w_nextState   = r_state;
    w_nextCount   = r_count;
    w_nextBtnOut  = r_btnOut;
    w_changePulse = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      SETTLED: begin
        if (w_syncLvl != r_btnOut) begin
          w_nextState = PENDING;
          w_nextCount = CNT_W'(1);
        end else begin
          w_nextCount = '0;
        end
      end
      PENDING: begin
        if (w_syncLvl == r_btnOut) begin
          w_nextState = SETTLED;
          w_nextCount = '0;
          w_abort     = 1'b1;
        end else if (r_count == CNT_LAST) begin
          w_nextState   = SETTLED;
          w_nextCount   = '0;
          w_nextBtnOut  = w_syncLvl;
          w_changePulse = 1'b1;
        end else begin
          w_nextCount = r_count + CNT_W'(1);
        end
      end
      default: begin
        w_nextState = SETTLED;
        w_nextCount = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] r_glitchCount;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_glitchCount <= 8'd0;
    end else if (w_abort && (r_glitchCount != 8'hFF)) begin
      r_glitchCount <= r_glitchCount + 8'd1;
    end
  end
`else
  logic w_abortUnused;
  assign w_abortUnused = w_abort;
`endif

  always_comb begin
    bus.btnOut      = r_btnOut;
    bus.stable      = r_stable;
    bus.btnChanged  = r_btnChanged;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    bus.glitchCount = r_glitchCount;
`endif
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the reaction timer's push-buttons.
- Synchronises a raw asynchronous button level into `clk`.
- Rejects contact bounce with a stability counter and FSM.
- Presents a clean level on `btnOut`, which drives the edge detector's `signalIn` directly; no further synchronisation downstream.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised cycles a new level must persist before `btnOut` changes; must be >= 2. Top level overrides to 1_000_000 (10 ms at 100 MHz).
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser; must be >= 2.
- RESET_LEVEL, 1'b0, value loaded into the synchroniser and `btnOut` on reset (button released).

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- btnIn  input  1  raw button level; asynchronous, may bounce.
- btnOut  output  1  debounced level, registered; feeds the edge detector.
- stable  output  1  high when the FSM is in SETTLED (no pending change).
- btnChanged  output  1  one-cycle pulse in the cycle `btnOut` takes a new value.

Behaviour:
Reset (asynchronous assert, synchronous-to-clk deassert is the top level's job):
- All synchroniser flops = RESET_LEVEL; `btnOut` = RESET_LEVEL.
- counter = 0; state = SETTLED.
- `stable` = 1; `btnChanged` = 0.

Synchroniser:
- SYNC_STAGES-flop shift chain; `syncLvl` = last stage.
- A change at `btnIn` appears on `syncLvl` SYNC_STAGES edges later.

Counter:
- Width = $clog2(STABLE_CYCLES).
- Never exceeds STABLE_CYCLES-1, so it never wraps.

FSM states:
- SETTLED:
  - `syncLvl` == `btnOut`: stay, counter = 0.
  - `syncLvl` != `btnOut`: go to PENDING, counter <= 1.
- PENDING:
  - `syncLvl` == `btnOut` (bounce back): return to SETTLED, counter <= 0, `btnOut` unchanged.
  - `syncLvl` != `btnOut` and counter == STABLE_CYCLES-1: `btnOut` <= `syncLvl`, `btnChanged` <= 1 for exactly one cycle, go to SETTLED, counter <= 0.
  - Otherwise: counter <= counter+1.

Outputs and timing:
- `stable` is registered: = (next state == SETTLED).
- Net latency from a clean `btnIn` step to `btnOut` change: SYNC_STAGES + STABLE_CYCLES clk edges, with 0 cycles of jitter once synchronised.
- Any mismatch run shorter than STABLE_CYCLES consecutive cycles never reaches `btnOut`.
- A bounce on the same cycle the counter hits terminal is decided by `syncLvl` at that edge only.

Boundary behaviour:
- `btnIn` held constant forever: `btnOut` constant, `btnChanged` never pulses.
- `rst` asserted mid-PENDING: pending change discarded; outputs return to reset values in the same cycle.
- `btnChanged` is never high for two consecutive cycles, because at least STABLE_CYCLES cycles separate changes.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Extra output port `glitchCount`, output, 8 bits.
  - Increments by 1 on every PENDING -> SETTLED transition without an output change.
  - Saturates at 8'hFF; reset to 0 by `rst`.
  - Used for board bring-up of button quality.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package `debounce_pkg`:
  - typedef enum logic [0:0] {SETTLED, PENDING} db_state_t.
  - Constants DB_DEFAULT_STABLE_CYCLES = 4 and DB_DEFAULT_SYNC_STAGES = 2.
  - Localparam function for counter width.
- Sub-module `sync_chain`:
  - Parameterised N-flop synchroniser with async reset value.
  - Reusable for other asynchronous inputs (switches).
  - `button_debouncer` instantiates one.

Test Plan:
All with STABLE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0.
1. Reset: hold `btnIn`=1 with `rst`=1 for 5 cycles -> `btnOut`=0, `stable`=1, `btnChanged`=0 throughout; release `rst` -> `btnOut` goes 1 exactly 6 edges later, with a single `btnChanged` pulse on that edge.
2. Clean press: `btnIn` 0->1 at edge 0, held -> `btnOut`=1 from edge 6; `stable`=0 during edges 3..5, 1 from edge 6.
3. Bounce rejection: `btnIn` pattern 1,0,1,0,1 each held 2 cycles, then 0 -> `btnOut` stays 0, `btnChanged` never pulses; with macro, `glitchCount` increments for each aborted PENDING.
4. Bounce then settle: `btnIn` toggles 1,0,1 at 1-cycle spacing, then held 1 -> `btnOut`=1 exactly 6 edges after the last 0->1 transition.
5. Reset mid-PENDING: `btnIn`=1, assert `rst` 2 cycles after `stable` drops -> `btnOut`=0, `stable`=1 immediately; after release, full 6-edge latency restarts.
6. Saturation (macro on): force 300 aborted bounces -> `glitchCount` = 8'hFF and holds.
